// File: rtl/fir_pkg.sv
// Shared types and constants for the symmetric FIR sample sequencer.
// Contents: FSM state enum, accumulator/index width helpers, default half-set coefficients.
// Default coefficients {1,2,3,4} describe an 8-tap symmetric filter (c[i] == c[TAPS-1-i]).
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  localparam int FIR_DEFAULT_N = 4;
  localparam int FIR_DEFAULT_COEFS [FIR_DEFAULT_N] = '{1, 2, 3, 4};

  // Full-precision accumulator width: product of a pre-added sample pair
  // (DATA_W+1) by a coefficient, summed over N = TAPS/2 pairs.
  function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + 1 + $clog2(taps / 2);
  endfunction

  // Pair-index width; never below one bit so a 2-tap build still has a counter.
  function automatic int fir_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default half-set coefficient i; pairs beyond the table default to zero.
  function automatic int fir_default_coef(input int i);
    if (i >= 0 && i < FIR_DEFAULT_N) begin
      return FIR_DEFAULT_COEFS[i];
    end
    return 0;
  endfunction

endpackage

// File: rtl/symmetric_mac_unit.sv
// Pre-add / multiply / accumulate element for one coefficient pair per cycle.
// Latency: acc_next is combinational from the current inputs; the accumulator register updates on en.
// Backpressure: none; the caller sequences clear/en.
// Ports: clk, rst (sync, active high), clear (zero acc), en (accumulate this cycle),
//        x_a/x_b (mirrored delay-line taps), coef (pair coefficient), acc_next (acc + this product).
module symmetric_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x_a,
  input  logic signed [DATA_W-1:0] x_b,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc_next
);

  localparam int PROD_W = DATA_W + COEF_W + 1;

  logic signed [DATA_W:0]   pre_sum;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;

  // Size casts on signed operands sign-extend, so every stage is full precision.
  assign pre_sum  = (DATA_W+1)'(x_a) + (DATA_W+1)'(x_b);
  assign prod     = PROD_W'(pre_sum) * PROD_W'(coef);
  assign acc_next = acc_q + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Symmetric even-length FIR: one filtered output per accepted sample strobe.
// Latency: out_valid pulses N+1 cycles after the strobe (N = TAPS/2 MAC cycles + DONE).
// Backpressure: none; strobes arriving while busy are dropped and flagged on sticky overrun.
// Ports: clk, rst (sync, active high), sample_strobe/sample_in (new sample),
//        out_valid/out_data (result pulse, data held between results), busy, overrun.
// Optional macro FIR_COEF_WR_EN adds coef_we/coef_addr/coef_wdata for runtime coefficient writes
// (accepted in IDLE only; rst restores the package defaults).
module fir_sample_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8      // must be even and >= 2
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            sample_strobe,
  input  logic signed [DATA_W-1:0]                        sample_in,
  output logic                                            out_valid,
  output logic signed [fir_acc_w(DATA_W,COEF_W,TAPS)-1:0] out_data,
  output logic                                            busy,
  output logic                                            overrun
`ifdef FIR_COEF_WR_EN
  ,
  input  logic                                            coef_we,
  input  logic [fir_idx_w(TAPS/2)-1:0]                    coef_addr,
  input  logic signed [COEF_W-1:0]                        coef_wdata
`endif
);

  localparam int N     = TAPS / 2;
  localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, TAPS);
  localparam int IDX_W = fir_idx_w(N);
  localparam int XI_W  = $clog2(TAPS);

  fir_state_e               state;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] x_q  [TAPS];
  logic signed [COEF_W-1:0] coef [N];

  logic [XI_W-1:0]          idx_lo;
  logic [XI_W-1:0]          idx_hi;
  logic                     last_pair;
  logic                     accept;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  acc_next;

  // Pair idx combines tap idx with its mirror TAPS-1-idx.
  assign idx_lo    = XI_W'(idx);
  assign idx_hi    = XI_W'(TAPS - 1) - idx_lo;
  assign last_pair = (idx == IDX_W'(N - 1));
  assign accept    = (state == IDLE) && sample_strobe;
  assign mac_en    = (state == MAC);

  symmetric_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (mac_en),
    .x_a      (x_q[idx_lo]),
    .x_b      (x_q[idx_hi]),
    .coef     (coef[idx]),
    .acc_next (acc_next)
  );

  // Coefficient store.
`ifdef FIR_COEF_WR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        coef[i] <= COEF_W'(fir_default_coef(i));
      end
    end else if (coef_we && (state == IDLE) && (int'(coef_addr) < N)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end
`else
  for (genvar g = 0; g < N; g++) begin : g_coef_const
    assign coef[g] = COEF_W'(fir_default_coef(g));
  end
`endif

  // Sequencer FSM, delay line and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;

      // Any strobe outside IDLE is lost; remember that it happened.
      if (sample_strobe && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sample_strobe) begin
            x_q[0] <= sample_in;
            for (int k = 1; k < TAPS; k++) begin
              x_q[k] <= x_q[k-1];
            end
            idx   <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end

        MAC: begin
          idx <= idx + IDX_W'(1);
          if (last_pair) begin
            // acc_next already includes the final pair's product.
            out_data  <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_sample_sequencer.md
# fir_sample_sequencer

Control and datapath stage that consumes the single-cycle sample strobe produced by the edge detector and computes one output of a symmetric, even-length FIR per strobe. On each accepted strobe it shifts the new sample into a delay line, then runs a time-multiplexed pre-add/multiply/accumulate over the TAPS/2 coefficient pairs. It presents the filtered result with a one-cycle valid pulse and sits between the edge detector and the output/sink logic of the filter.

## Interface

Parameters:
- DATA_W, 16: signed sample width.
- COEF_W, 16: signed coefficient width.
- TAPS, 8: filter length; must be even and ≥ 2. N = TAPS/2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_strobe  in  1  one-cycle pulse marking a new sample (edge-detector output).
- sample_in  in  DATA_W  signed sample, valid in the strobe cycle.
- out_valid  out  1  one-cycle pulse; out_data is valid.
- out_data  out  ACC_W  signed result, ACC_W = DATA_W+COEF_W+1+$clog2(N).
- busy  out  1  high while state ≠ IDLE.
- overrun  out  1  sticky; a strobe arrived while busy.
- coef_we / coef_addr / coef_wdata  in  1 / $clog2(N) / COEF_W  present only with FIR_COEF_WR_EN.

## Operation

- FSM states: IDLE, MAC, DONE.
- IDLE: on sample_strobe, x[0]←sample_in, x[k]←x[k-1], acc←0, idx←0, and go to MAC.
- MAC: each cycle acc += c[idx]·(x[idx] + x[TAPS-1-idx]); idx++. After idx = N-1 is processed, go to DONE.
- DONE: out_data←acc, out_valid=1 for this cycle only, then go to IDLE.
- Arithmetic: pre-add DATA_W+1 bits, sign-extended; product DATA_W+COEF_W+1 bits; acc ACC_W bits. Full precision, so no saturation or rounding is needed.
- Strobe is accepted only in IDLE. A strobe in MAC or DONE drops the sample, leaves the delay line unchanged, and sets overrun. overrun clears only on rst.
- out_data holds its last value between results.
- Reset mid-operation: computation aborts, no out_valid is issued, and all state returns to reset values.

## Timing

- Reset values: out_valid=0, out_data=0, busy=0, overrun=0, delay line all zero, acc=0, state=IDLE.
- Strobe high in cycle 0:
  - MAC runs in cycles 1..N.
  - out_valid is high in cycle N+1.
  - busy is high in cycles 1..N+1.
- Minimum strobe spacing without overrun: N+2 cycles (6 for TAPS=8).
- A strobe coincident with rst is ignored.

## Configuration

- FIR_COEF_WR_EN defined:
  - coef_* ports exist.
  - A write with coef_we=1 in IDLE updates c[coef_addr] at the next edge.
  - A write while busy is ignored.
  - rst reloads package defaults.
- FIR_COEF_WR_EN undefined: no coef_* ports; coefficients are the constant package defaults.

## Structure

- Package fir_pkg holds:
  - the state enum typedef (IDLE, MAC, DONE);
  - the function that computes ACC_W;
  - the default coefficient array FIR_DEFAULT_COEFS (half-set, N entries; TAPS=8 default {1,2,3,4}).
- Sub-module symmetric_mac_unit holds pre-adder, multiplier and accumulator with clear/enable. The top level holds the FSM, delay line and coefficient store.

## Test plan

- Impulse: TAPS=8, default coefs, strobe sample 1 then 7 strobes of 0 spaced 8 cycles apart -> out_data sequence 1,2,3,4,4,3,2,1; each out_valid arrives exactly 5 cycles after its strobe.
- Negative full-scale: 8 strobes of -32768 -> final out_data = -32768·20 = -655360, overrun=0.
- Overrun: strobe, then a second strobe 2 cycles later -> overrun=1 and stays 1; one out_valid, result computed from first sample only; delay line shifted once.
- Reset mid-MAC: strobe, rst in cycle 2 -> no out_valid; all outputs 0 next cycle; next strobe of 5 yields 5·c0=5.
- Back-to-back at minimum spacing: strobes every 6 cycles for 20 samples -> 20 out_valid pulses, overrun=0.
- FIR_COEF_WR_EN: write c[0]=7 in IDLE, then impulse 1 -> first out_data=7. Write attempted while busy -> no effect.
